ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Two-port arbiter/sequencer in front of the single ram_sync instance.
- Port A serves the CPU-side bus (ram_* from bus); port B serves a DMA master (RK/IDE block transfers).
- Grants one requester at a time, registers address/data/byte_op into the RAM strobes, times the access, and returns a one-cycle ack plus read data.
- Round-robin on contention; a completed access must be released before the next grant.

Parameters:
- RD_LATENCY, 1, cycles ram_rd is held before ram_data_in is captured (1..7)
- WR_CYCLES, 1, cycles ram_wr is held per write (1..7)

Ports:
- clk  in  1  system clock, all state on posedge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- a_addr  in  22  port A physical address
- a_data_in  in  16  port A write data
- a_rd / a_wr  in  1 each  port A read / write request
- a_byte_op  in  1  port A byte access
- a_data_out  out  16  port A read data, registered
- a_ack  out  1  port A completion pulse
- b_addr, b_data_in, b_rd, b_wr, b_byte_op, b_data_out, b_ack  same as port A, for port B
- ram_addr  out  22  RAM address, registered
- ram_data_out  out  16  RAM write data, registered
- ram_data_in  in  16  RAM read data
- ram_rd / ram_wr  out  1 each  RAM strobes, registered
- ram_byte_op  out  1  registered byte flag
- grant  out  2  01 = A owns RAM, 10 = B owns RAM, 00 = idle
- busy  out  1  state != IDLE

Behaviour:
- Reset values: all outputs 0, state IDLE, counter 0, last_grant = A.
- Reset mid-access drops all strobes immediately; no ack is issued.
- A port is "pending" when its rd | wr is high. If rd and wr are both high, the access is a write.

States:
- IDLE
  - Neither pending: stay.
  - One pending: grant it.
  - Both pending: grant the port that is not last_grant.
  - On the grant edge:
    - latch addr, data_in, byte_op into ram_addr, ram_data_out, ram_byte_op.
    - Set ram_rd or ram_wr.
    - Set grant and last_grant.
    - Load counter with RD_LATENCY (read) or WR_CYCLES (write).
    - Go to ACCESS.
- ACCESS
  - Strobe held; ram_addr, ram_data_out and ram_byte_op stay stable.
  - Counter decrements each edge.
  - On the edge where counter reaches 1:
    - clear the strobe.
    - For a read, capture ram_data_in into the granted port's data_out.
    - Assert that port's ack.
    - Go to ACK.
- ACK
  - ack high for exactly this one cycle.
  - Next edge: ack cleared, go to RELEASE.
- RELEASE
  - grant is held.
  - Wait until the granted port's rd and wr are both low, then go to IDLE and set grant = 00.
  - The other port's request is never serviced from RELEASE; it waits for IDLE.

Timing and data rules:
- Timing with RD_LATENCY=1: request sampled at edge 0 → ram_rd high cycle 0→1 → a_ack high cycle 1→2 with a_data_out valid.
  - The ack edge is RD_LATENCY edges after the grant edge.
  - Minimum back-to-back spacing for one port is RD_LATENCY+3 edges.
- A request dropped during ACCESS does not abort: the access completes, ack still pulses, and RELEASE exits on the next edge.
- Byte ops pass ram_byte_op through unchanged; address bit 0 and lane selection belong to ram_sync. The data path is not modified.
- a_data_out / b_data_out hold their last read value; writes leave them unchanged.
- Request-line changes of the non-granted port during a transfer have no effect.
- last_grant is updated only on a grant, so alternation holds under continuous contention: A, B, A, B, ...

Test Plan:
- Reset 40ns, single A read of 0o001000 with RAM returning 0o012345, RD_LATENCY=1 → ram_rd one cycle, ram_addr=0o001000, a_ack one cycle later, a_data_out=0o012345, grant 01 → 00 after a_rd drops.
- B byte write of 0o377 to 0o000101 → ram_wr one cycle, ram_byte_op=1, ram_data_out=0o000377, b_ack pulse, a_data_out unchanged.
- A and B both reading from the cycle after reset → B granted first, then A, then B; each port receives exactly one ack per access; no overlapping strobes.
- A holds a_rd high for 5 cycles after ack → arbiter stays in RELEASE, no second grant, no extra ack. B pending meanwhile is granted on the cycle after a_rd drops.
- RD_LATENCY=3, WR_CYCLES=2 → ram_rd high 3 cycles and ram_wr high 2 cycles, with ack immediately following; a_rd and a_wr high together is performed as a write.
- Reset asserted mid-ACCESS → ram_rd, ram_wr, ack and grant go to 0 asynchronously; after release, a new request is serviced normally with B-first tie-break.

Source files
------------

// File: rtl/ram_arbiter.sv
// Round-robin arbiter that sequences CPU (port A) and DMA (port B) accesses onto a single
// synchronous RAM. It times each strobe, then returns a one-cycle ack and the read data.
module ram_arbiter #(
    parameter int RD_LATENCY = 1,
    parameter int WR_CYCLES  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [21:0] a_addr,
    input  logic [15:0] a_data_in,
    input  logic        a_rd,
    input  logic        a_wr,
    input  logic        a_byte_op,
    output logic [15:0] a_data_out,
    output logic        a_ack,
    input  logic [21:0] b_addr,
    input  logic [15:0] b_data_in,
    input  logic        b_rd,
    input  logic        b_wr,
    input  logic        b_byte_op,
    output logic [15:0] b_data_out,
    output logic        b_ack,
    output logic [21:0] ram_addr,
    output logic [15:0] ram_data_out,
    input  logic [15:0] ram_data_in,
    output logic        ram_rd,
    output logic        ram_wr,
    output logic        ram_byte_op,
    output logic [1:0]  grant,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, ACK, RELEASE} state_t;

    localparam logic [2:0] RD_CNT = 3'(RD_LATENCY);
    localparam logic [2:0] WR_CNT = 3'(WR_CYCLES);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        last_b_q, last_b_d;
    logic [1:0]  grant_q, grant_d;
    logic [21:0] ram_addr_q, ram_addr_d;
    logic [15:0] ram_data_out_q, ram_data_out_d;
    logic        ram_byte_op_q, ram_byte_op_d;
    logic        ram_rd_q, ram_rd_d;
    logic        ram_wr_q, ram_wr_d;
    logic        a_ack_q, a_ack_d;
    logic        b_ack_q, b_ack_d;
    logic [15:0] a_data_out_q, a_data_out_d;
    logic [15:0] b_data_out_q, b_data_out_d;

    logic a_pend, b_pend, pick_b, sel_wr;

    assign a_pend = a_rd | a_wr;
    assign b_pend = b_rd | b_wr;
    // B wins when it is alone, or when both contend and A was served last.
    assign pick_b = b_pend & (~a_pend | ~last_b_q);
    assign sel_wr = pick_b ? b_wr : a_wr;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        last_b_d       = last_b_q;
        grant_d        = grant_q;
        ram_addr_d     = ram_addr_q;
        ram_data_out_d = ram_data_out_q;
        ram_byte_op_d  = ram_byte_op_q;
        ram_rd_d       = ram_rd_q;
        ram_wr_d       = ram_wr_q;
        a_ack_d        = a_ack_q;
        b_ack_d        = b_ack_q;
        a_data_out_d   = a_data_out_q;
        b_data_out_d   = b_data_out_q;

        case (state_q)
            IDLE: begin
                if (a_pend | b_pend) begin
                    ram_addr_d     = pick_b ? b_addr    : a_addr;
                    ram_data_out_d = pick_b ? b_data_in : a_data_in;
                    ram_byte_op_d  = pick_b ? b_byte_op : a_byte_op;
                    ram_wr_d       = sel_wr;
                    ram_rd_d       = ~sel_wr;
                    grant_d        = pick_b ? 2'b10 : 2'b01;
                    last_b_d       = pick_b;
                    cnt_d          = sel_wr ? WR_CNT : RD_CNT;
                    state_d        = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q <= 3'd1) begin
                    ram_rd_d = 1'b0;
                    ram_wr_d = 1'b0;
                    cnt_d    = 3'd0;
                    if (ram_rd_q) begin
                        if (grant_q[1]) b_data_out_d = ram_data_in;
                        else            a_data_out_d = ram_data_in;
                    end
                    if (grant_q[1]) b_ack_d = 1'b1;
                    else            a_ack_d = 1'b1;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ACK: begin
                a_ack_d = 1'b0;
                b_ack_d = 1'b0;
                state_d = RELEASE;
            end
            RELEASE: begin
                // The owner must drop its request before anyone else can be granted.
                if (grant_q[1] ? ~b_pend : ~a_pend) begin
                    grant_d = 2'b00;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= 3'd0;
            last_b_q       <= 1'b0;
            grant_q        <= 2'b00;
            ram_addr_q     <= 22'd0;
            ram_data_out_q <= 16'd0;
            ram_byte_op_q  <= 1'b0;
            ram_rd_q       <= 1'b0;
            ram_wr_q       <= 1'b0;
            a_ack_q        <= 1'b0;
            b_ack_q        <= 1'b0;
            a_data_out_q   <= 16'd0;
            b_data_out_q   <= 16'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            last_b_q       <= last_b_d;
            grant_q        <= grant_d;
            ram_addr_q     <= ram_addr_d;
            ram_data_out_q <= ram_data_out_d;
            ram_byte_op_q  <= ram_byte_op_d;
            ram_rd_q       <= ram_rd_d;
            ram_wr_q       <= ram_wr_d;
            a_ack_q        <= a_ack_d;
            b_ack_q        <= b_ack_d;
            a_data_out_q   <= a_data_out_d;
            b_data_out_q   <= b_data_out_d;
        end
    end

    assign a_data_out   = a_data_out_q;
    assign a_ack        = a_ack_q;
    assign b_data_out   = b_data_out_q;
    assign b_ack        = b_ack_q;
    assign ram_addr     = ram_addr_q;
    assign ram_data_out = ram_data_out_q;
    assign ram_rd       = ram_rd_q;
    assign ram_wr       = ram_wr_q;
    assign ram_byte_op  = ram_byte_op_q;
    assign grant        = grant_q;
    assign busy         = (state_q != IDLE);
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios on two parameterisations plus a randomized
// two-master run checked against a transaction-level model of the arbiter and RAM.
module tb_ram_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Port requests, index 0 = A, 1 = B
    logic [1:0][21:0] r_addr;
    logic [1:0][15:0] r_din;
    logic [1:0]       r_rd, r_wr, r_byte;

    logic [15:0] a_data_out, b_data_out, ram_data_out, ram_data_in;
    logic [21:0] ram_addr;
    logic        a_ack, b_ack, ram_rd, ram_wr, ram_byte_op, busy;
    logic [1:0]  grant;

    ram_arbiter #(.RD_LATENCY(1), .WR_CYCLES(1)) u_dut (
        .clk(clk), .reset(reset),
        .a_addr(r_addr[0]), .a_data_in(r_din[0]), .a_rd(r_rd[0]), .a_wr(r_wr[0]),
        .a_byte_op(r_byte[0]), .a_data_out(a_data_out), .a_ack(a_ack),
        .b_addr(r_addr[1]), .b_data_in(r_din[1]), .b_rd(r_rd[1]), .b_wr(r_wr[1]),
        .b_byte_op(r_byte[1]), .b_data_out(b_data_out), .b_ack(b_ack),
        .ram_addr(ram_addr), .ram_data_out(ram_data_out), .ram_data_in(ram_data_in),
        .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_byte_op(ram_byte_op),
        .grant(grant), .busy(busy)
    );

    // RAM behind the first instance; preload path used only while in reset
    logic [15:0] mem [256];
    logic [15:0] ref_mem [256];
    logic        pre_we;
    logic [7:0]  pre_addr;
    logic [15:0] pre_data;
    always @(posedge clk) begin
        if (pre_we)      mem[pre_addr] <= pre_data;
        else if (ram_wr) mem[ram_addr[7:0]] <= ram_data_out;
    end
    assign ram_data_in = mem[ram_addr[7:0]];

    // Second instance with longer strobes; its RAM returns an address-derived pattern
    logic [21:0] c_addr;
    logic [15:0] c_din;
    logic        c_rd, c_wr, c_byte;
    logic [15:0] x_a_data_out, x_b_data_out, x_ram_data_out, x_ram_data_in;
    logic [21:0] x_ram_addr;
    logic        x_a_ack, x_b_ack, x_ram_rd, x_ram_wr, x_ram_byte_op, x_busy;
    logic [1:0]  x_grant;

    ram_arbiter #(.RD_LATENCY(3), .WR_CYCLES(2)) u_dut2 (
        .clk(clk), .reset(reset),
        .a_addr(c_addr), .a_data_in(c_din), .a_rd(c_rd), .a_wr(c_wr),
        .a_byte_op(c_byte), .a_data_out(x_a_data_out), .a_ack(x_a_ack),
        .b_addr(22'd0), .b_data_in(16'd0), .b_rd(1'b0), .b_wr(1'b0),
        .b_byte_op(1'b0), .b_data_out(x_b_data_out), .b_ack(x_b_ack),
        .ram_addr(x_ram_addr), .ram_data_out(x_ram_data_out), .ram_data_in(x_ram_data_in),
        .ram_rd(x_ram_rd), .ram_wr(x_ram_wr), .ram_byte_op(x_ram_byte_op),
        .grant(x_grant), .busy(x_busy)
    );
    assign x_ram_data_in = x_ram_addr[15:0] ^ 16'ha5a5;

    int checks;
    int failures;

    task automatic reset_pulse();
        reset = 1'b1;
        r_rd = '0; r_wr = '0; r_byte = '0;
        c_rd = 1'b0; c_wr = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        r_addr = '0; r_din = '0; r_rd = '0; r_wr = '0; r_byte = '0;
        c_addr = '0; c_din = '0; c_rd = 1'b0; c_wr = 1'b0; c_byte = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if ({grant, busy, ram_rd, ram_wr, ram_byte_op, a_ack, b_ack} !== 8'd0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0", {grant, busy, ram_rd, ram_wr, ram_byte_op, a_ack, b_ack});
        end
        checks++;
        if ({ram_addr, ram_data_out, a_data_out, b_data_out} !== 70'd0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", {ram_addr, ram_data_out, a_data_out, b_data_out});
        end
        checks++;
        if ({x_grant, x_busy, x_ram_rd, x_ram_wr, x_a_ack, x_a_data_out} !== 22'd0) begin
            failures++;
            $display("FAIL reset_dut2 got=%h exp=0", {x_grant, x_busy, x_ram_rd, x_ram_wr, x_a_ack, x_a_data_out});
        end
        for (int i = 0; i < 256; i++) begin
            pre_we = 1'b1;
            pre_addr = i[7:0];
            pre_data = (i == 0) ? 16'o012345 : 16'($urandom);
            ref_mem[i] = pre_data;
            @(negedge clk);
        end
        pre_we = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        r_addr[0] = 22'o001000; r_rd[0] = 1'b1;
        @(negedge clk);
        checks++;
        if ({ram_rd, ram_wr, grant, a_ack, busy} !== 6'b10_01_0_1 || ram_addr !== 22'o001000) begin
            failures++;
            $display("FAIL rd_grant got=%b addr=%o exp=100101 addr=001000", {ram_rd, ram_wr, grant, a_ack, busy}, ram_addr);
        end
        @(negedge clk);
        checks++;
        if ({ram_rd, a_ack} !== 2'b01) begin
            failures++;
            $display("FAIL rd_ack got=%b exp=01", {ram_rd, a_ack});
        end
        checks++;
        if (a_data_out !== 16'o012345) begin
            failures++;
            $display("FAIL rd_data got=%o exp=012345", a_data_out);
        end
        r_rd[0] = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_ack, grant} !== 3'b0_01) begin
            failures++;
            $display("FAIL rd_ackstate got=%b exp=001", {a_ack, grant});
        end
        @(negedge clk);
        checks++;
        if ({grant, busy} !== 3'b000) begin
            failures++;
            $display("FAIL rd_release got=%b exp=000", {grant, busy});
        end
    endtask

    task automatic test_byte_write();
        logic [15:0] a_prev;
        a_prev = a_data_out;
        r_addr[1] = 22'o000101; r_din[1] = 16'o000377; r_wr[1] = 1'b1; r_byte[1] = 1'b1;
        @(negedge clk);
        checks++;
        if ({ram_wr, ram_rd, ram_byte_op, grant} !== 5'b1_0_1_10 || ram_data_out !== 16'o000377
            || ram_addr !== 22'o000101) begin
            failures++;
            $display("FAIL bw_grant got=%b data=%o addr=%o exp=10110 data=000377 addr=000101",
                     {ram_wr, ram_rd, ram_byte_op, grant}, ram_data_out, ram_addr);
        end
        @(negedge clk);
        checks++;
        if ({ram_wr, b_ack, a_ack} !== 3'b010 || a_data_out !== a_prev) begin
            failures++;
            $display("FAIL bw_ack got=%b a_data=%o exp=010 a_data=%o", {ram_wr, b_ack, a_ack}, a_data_out, a_prev);
        end
        r_wr[1] = 1'b0; r_byte[1] = 1'b0;
        ref_mem[8'o101] = 16'o000377;
        repeat (2) @(negedge clk);
        checks++;
        if ({grant, b_ack} !== 3'b000) begin
            failures++;
            $display("FAIL bw_release got=%b exp=000", {grant, b_ack});
        end
    endtask

    task automatic test_contention();
        logic [1:0] exp_g, prev_g;
        int ng, na, nb, overlap, bad_order;
        int low [2];
        r_addr[0] = 22'o000002; r_addr[1] = 22'o000003;
        reset = 1'b1; r_rd = '0; r_wr = '0;
        @(negedge clk);
        reset = 1'b0; r_rd = 2'b11;
        exp_g = 2'b10; prev_g = 2'b00;
        ng = 0; na = 0; nb = 0; overlap = 0; bad_order = 0; low[0] = 0; low[1] = 0;
        for (int cyc = 0; cyc < 60 && (na + nb) < 6; cyc++) begin
            @(negedge clk);
            if (ram_rd && ram_wr) overlap++;
            if (grant !== 2'b00 && prev_g === 2'b00) begin
                if (grant !== exp_g) bad_order++;
                exp_g = {exp_g[0], exp_g[1]};
                ng++;
            end
            prev_g = grant;
            if (a_ack) na++;
            if (b_ack) nb++;
            for (int p = 0; p < 2; p++) begin
                if ((p == 0) ? a_ack : b_ack) begin
                    r_rd[p] = 1'b0; low[p] = 2;
                end else if (low[p] > 0) begin
                    low[p]--;
                    if (low[p] == 0) r_rd[p] = 1'b1;
                end
            end
        end
        r_rd = '0;
        checks++;
        if (bad_order != 0 || ng != 6) begin
            failures++;
            $display("FAIL rr_order got=bad%0d grants%0d exp=bad0 grants6", bad_order, ng);
        end
        checks++;
        if (na != 3 || nb != 3) begin
            failures++;
            $display("FAIL rr_acks got=a%0d b%0d exp=a3 b3", na, nb);
        end
        checks++;
        if (overlap != 0) begin
            failures++;
            $display("FAIL rr_overlap got=%0d exp=0", overlap);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_hold();
        int extra, bad;
        reset_pulse();
        r_addr[0] = 22'o000004; r_rd[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (grant !== 2'b01) begin
            failures++;
            $display("FAIL hold_grant got=%b exp=01", grant);
        end
        r_addr[1] = 22'o000005; r_rd[1] = 1'b1;
        @(negedge clk);
        checks++;
        if (a_ack !== 1'b1) begin
            failures++;
            $display("FAIL hold_ack got=%b exp=1", a_ack);
        end
        extra = 0; bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (a_ack || b_ack || ram_rd || ram_wr) extra++;
            if (grant !== 2'b01) bad++;
        end
        checks++;
        if (extra != 0 || bad != 0) begin
            failures++;
            $display("FAIL hold_release got=extra%0d badgrant%0d exp=0 0", extra, bad);
        end
        r_rd[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (grant !== 2'b00) begin
            failures++;
            $display("FAIL hold_idle got=%b exp=00", grant);
        end
        @(negedge clk);
        checks++;
        if ({grant, ram_rd} !== 3'b10_1 || ram_addr !== 22'o000005) begin
            failures++;
            $display("FAIL hold_bgrant got=%b addr=%o exp=101 addr=000005", {grant, ram_rd}, ram_addr);
        end
        @(negedge clk);
        checks++;
        if (b_ack !== 1'b1 || b_data_out !== ref_mem[5]) begin
            failures++;
            $display("FAIL hold_bdata got=%b %h exp=1 %h", b_ack, b_data_out, ref_mem[5]);
        end
        r_rd[1] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_long_latency();
        int nrd, nwr, ack_at, last_s, bad_d;
        logic [15:0] exp_rd;
        c_addr = 22'h2abcd; c_rd = 1'b1;
        exp_rd = 16'habcd ^ 16'ha5a5;
        nrd = 0; nwr = 0; ack_at = -1; last_s = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (x_ram_rd) begin nrd++; last_s = i; end
            if (x_ram_wr) begin nwr++; last_s = i; end
            if (x_a_ack) begin ack_at = i; break; end
        end
        checks++;
        if (nrd != 3 || nwr != 0 || ack_at != last_s + 1) begin
            failures++;
            $display("FAIL lat_rd got=rd%0d wr%0d ack%0d last%0d exp=rd3 wr0 ack=last+1", nrd, nwr, ack_at, last_s);
        end
        checks++;
        if (x_a_data_out !== exp_rd) begin
            failures++;
            $display("FAIL lat_rddata got=%h exp=%h", x_a_data_out, exp_rd);
        end
        c_rd = 1'b0;
        repeat (2) @(negedge clk);
        c_addr = 22'h00042; c_din = 16'h1357; c_rd = 1'b1; c_wr = 1'b1;
        nrd = 0; nwr = 0; ack_at = -1; last_s = -1; bad_d = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (x_ram_rd) begin nrd++; last_s = i; end
            if (x_ram_wr) begin
                nwr++; last_s = i;
                if (x_ram_data_out !== 16'h1357 || x_ram_addr !== 22'h00042) bad_d++;
            end
            if (x_a_ack) begin ack_at = i; break; end
        end
        checks++;
        if (nwr != 2 || nrd != 0 || ack_at != last_s + 1) begin
            failures++;
            $display("FAIL lat_wr got=wr%0d rd%0d ack%0d last%0d exp=wr2 rd0 ack=last+1", nwr, nrd, ack_at, last_s);
        end
        checks++;
        if (bad_d != 0 || x_a_data_out !== exp_rd) begin
            failures++;
            $display("FAIL lat_wrdata got=bad%0d out=%h exp=bad0 out=%h", bad_d, x_a_data_out, exp_rd);
        end
        c_rd = 1'b0; c_wr = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int acks;
        r_addr[0] = 22'o000010; r_rd[0] = 1'b1;
        c_addr = 22'h00010; c_rd = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1; r_rd[0] = 1'b0; c_rd = 1'b0;
        #1;
        checks++;
        if ({ram_rd, ram_wr, a_ack, b_ack, grant, busy} !== 7'd0) begin
            failures++;
            $display("FAIL rstmid_dut1 got=%b exp=0", {ram_rd, ram_wr, a_ack, b_ack, grant, busy});
        end
        checks++;
        if ({x_ram_rd, x_ram_wr, x_a_ack, x_grant, x_busy} !== 6'd0) begin
            failures++;
            $display("FAIL rstmid_dut2 got=%b exp=0", {x_ram_rd, x_ram_wr, x_a_ack, x_grant, x_busy});
        end
        acks = 0;
        @(negedge clk);
        if (a_ack || x_a_ack) acks++;
        reset = 1'b0;
        r_addr[0] = 22'o000011; r_addr[1] = 22'o000012; r_rd = 2'b11;
        @(negedge clk);
        if (a_ack || x_a_ack) acks++;
        checks++;
        if (acks != 0 || {grant, ram_rd} !== 3'b10_1 || ram_addr !== 22'o000012) begin
            failures++;
            $display("FAIL rstmid_after got=acks%0d %b addr=%o exp=acks0 101 addr=000012", acks, {grant, ram_rd}, ram_addr);
        end
        @(negedge clk);
        r_rd = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        int m_st, m_own, m_last, m_rem, n_acks;
        logic m_wr, m_byte, e_rd, e_wr, e_aa, e_ba;
        logic [21:0] m_addr;
        logic [15:0] m_data;
        logic [15:0] m_dout [2];
        logic [1:0]  e_g;
        int ph [2];
        int cnt [2];
        reset_pulse();
        m_st = 0; m_own = 0; m_last = 0; m_rem = 0; n_acks = 0;
        m_wr = 1'b0; m_byte = 1'b0; m_addr = '0; m_data = '0;
        m_dout[0] = '0; m_dout[1] = '0;
        ph[0] = 0; ph[1] = 0; cnt[0] = 0; cnt[1] = 1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            case (m_st)
                0: if ((r_rd | r_wr) != 2'b00) begin
                    m_own  = ((r_rd[1] | r_wr[1]) && (!(r_rd[0] | r_wr[0]) || m_last == 0)) ? 1 : 0;
                    m_last = m_own;
                    m_wr   = r_wr[m_own];
                    m_addr = r_addr[m_own];
                    m_data = r_din[m_own];
                    m_byte = r_byte[m_own];
                    m_rem  = 1;
                    m_st   = 1;
                end
                1: begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_st = 2;
                        n_acks++;
                        if (m_wr) ref_mem[m_addr[7:0]] = m_data;
                        else      m_dout[m_own] = ref_mem[m_addr[7:0]];
                    end
                end
                2: m_st = 3;
                default: if (!(r_rd[m_own] | r_wr[m_own])) m_st = 0;
            endcase
            e_g  = (m_st == 0) ? 2'b00 : ((m_own == 1) ? 2'b10 : 2'b01);
            e_rd = (m_st == 1) && !m_wr;
            e_wr = (m_st == 1) && m_wr;
            e_aa = (m_st == 2) && (m_own == 0);
            e_ba = (m_st == 2) && (m_own == 1);
            checks++;
            if ({grant, ram_rd, ram_wr, a_ack, b_ack, a_data_out, b_data_out}
                !== {e_g, e_rd, e_wr, e_aa, e_ba, m_dout[0], m_dout[1]}) begin
                failures++;
                $display("FAIL rnd_cycle%0d got=%b %b %b %b %b %h %h exp=%b %b %b %b %b %h %h", cyc,
                         grant, ram_rd, ram_wr, a_ack, b_ack, a_data_out, b_data_out,
                         e_g, e_rd, e_wr, e_aa, e_ba, m_dout[0], m_dout[1]);
            end
            if (m_st == 1) begin
                checks++;
                if ({ram_addr, ram_byte_op} !== {m_addr, m_byte} || (m_wr && ram_data_out !== m_data)) begin
                    failures++;
                    $display("FAIL rnd_strobe%0d got=%h %b %h exp=%h %b %h", cyc,
                             ram_addr, ram_byte_op, ram_data_out, m_addr, m_byte, m_data);
                end
            end
            for (int p = 0; p < 2; p++) begin
                case (ph[p])
                    0: if (cnt[p] == 0) begin
                        r_addr[p] = {14'($urandom), 8'($urandom)};
                        r_din[p]  = 16'($urandom);
                        r_wr[p]   = 1'($urandom_range(0, 1));
                        r_rd[p]   = r_wr[p] ? 1'($urandom_range(0, 1)) : 1'b1;
                        r_byte[p] = 1'($urandom_range(0, 1));
                        ph[p] = 1;
                    end else cnt[p]--;
                    1: if (m_st == 2 && m_own == p) begin
                        ph[p] = 2; cnt[p] = $urandom_range(0, 3);
                    end else if (!(m_st != 0 && m_own == p) && $urandom_range(0, 3) == 0) begin
                        r_addr[p] = {14'($urandom), 8'($urandom)};
                        r_din[p]  = 16'($urandom);
                    end
                    default: if (cnt[p] == 0) begin
                        r_rd[p] = 1'b0; r_wr[p] = 1'b0; ph[p] = 0; cnt[p] = $urandom_range(0, 4);
                    end else cnt[p]--;
                endcase
            end
        end
        r_rd = '0; r_wr = '0;
        repeat (4) @(negedge clk);
        checks++;
        if (n_acks < 20) begin
            failures++;
            $display("FAIL rnd_activity got=%0d exp>=20", n_acks);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_single_read();
        test_byte_write();
        test_contention();
        test_hold();
        test_long_latency();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
